// File: rtl/res_pkg.sv
// Shared types and width helpers for the result collector.
package res_pkg;

    localparam int unsigned DEF_NUM = 100;
    localparam int unsigned PKG_W   = DEF_NUM * 8;

    typedef enum logic {
        COLLECT,
        HOLD
    } coll_state_t;

    function automatic int unsigned clog2(input int unsigned x);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(x)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned pkg_bits(input int unsigned num);
        return num * 8;
    endfunction

endpackage

// File: rtl/res_collector_if.sv
// Result-stream and package handshake bundle between DUT side and testbench side.
interface res_collector_if
    import res_pkg::*;
#(
    parameter int unsigned NUM   = 100,
    parameter int unsigned CNT_W = 16
);
    logic [7:0]                 res_i;
    logic                       op_valid_i;
    logic                       pkg_ready_i;
    logic [pkg_bits(NUM)-1:0]   pkg_data_o;
    logic                       pkg_valid_o;
    logic [clog2(NUM+1)-1:0]    byte_cnt_o;
    logic [CNT_W-1:0]           drop_cnt_o;
    logic                       overflow_o;

    modport master (
        input  res_i, op_valid_i, pkg_ready_i,
        output pkg_data_o, pkg_valid_o, byte_cnt_o, drop_cnt_o, overflow_o
    );

    modport slave (
        output res_i, op_valid_i, pkg_ready_i,
        input  pkg_data_o, pkg_valid_o, byte_cnt_o, drop_cnt_o, overflow_o
    );
endinterface

// File: rtl/valid_delay_line.sv
// Delays the operand-valid strobe by DEPTH cycles; DEPTH=0 is a combinational bypass.
module valid_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_valid
);
    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_reset;
            assign o_valid  = i_valid;
        end else begin : g_pipe
            logic [DEPTH-1:0] r_sr;
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= (r_sr << 1) | DEPTH'(i_valid);
                end
            end
            assign o_valid = r_sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/res_collector.sv
// Captures delay-aligned DUT result bytes LSB-first into a NUM-byte package
// and holds it on a valid/ready handshake, counting bytes lost while holding.
module res_collector
    import res_pkg::*;
#(
    parameter int unsigned NUM     = 100,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    res_collector_if.master   bus
);
    localparam int unsigned PW   = pkg_bits(NUM);
    localparam int unsigned BC_W = clog2(NUM + 1);

    logic              w_cap_v;
    coll_state_t       r_state;
    logic [PW-1:0]     r_data;
    logic              r_valid;
    logic [BC_W-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_drop;
    logic              r_ovf;

    valid_delay_line #(
        .DEPTH (LATENCY)
    ) u_dly (
        .i_clk   (clk_i),
        .i_reset (reset_i),
        .i_valid (bus.op_valid_i),
        .o_valid (w_cap_v)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= COLLECT;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_cap_v) begin
                        for (int unsigned k = 0; k < NUM; k++) begin
                            if (r_cnt == BC_W'(k)) begin
                                r_data[k*8 +: 8] <= bus.res_i;
                            end
                        end
                        r_cnt <= r_cnt + BC_W'(1);
                        if (r_cnt == BC_W'(NUM - 1)) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.pkg_ready_i) begin
                        // A byte arriving on the handshake cycle opens the next package.
                        r_state <= COLLECT;
                        r_valid <= 1'b0;
                        if (w_cap_v) begin
                            r_data <= PW'(bus.res_i);
                            r_cnt  <= BC_W'(1);
                        end else begin
                            r_data <= '0;
                            r_cnt  <= '0;
                        end
                    end else if (w_cap_v) begin
                        r_ovf <= 1'b1;
                        if (r_drop != '1) begin
                            r_drop <= r_drop + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign bus.pkg_data_o  = r_data;
    assign bus.pkg_valid_o = r_valid;
    assign bus.byte_cnt_o  = r_cnt;
    assign bus.drop_cnt_o  = r_drop;
    assign bus.overflow_o  = r_ovf;
endmodule

// File: tb/tb_res_collector.sv
// Directed checks of res_collector across latency and counter-width variants.
module tb_res_collector;

    logic       clk;
    logic       rst;
    logic       op_v;
    logic       rdy;
    logic [7:0] res_v;
    int         sel;
    int         n_chk;
    int         n_err;

    res_collector_if #(.NUM(4), .CNT_W(16)) ifa ();
    res_collector_if #(.NUM(4), .CNT_W(16)) ifb ();
    res_collector_if #(.NUM(4), .CNT_W(16)) ifc ();
    res_collector_if #(.NUM(4), .CNT_W(2))  ifd ();

    assign ifa.res_i = res_v;
    assign ifb.res_i = res_v;
    assign ifc.res_i = res_v;
    assign ifd.res_i = res_v;
    assign ifa.op_valid_i  = op_v & (sel == 0);
    assign ifb.op_valid_i  = op_v & (sel == 1);
    assign ifc.op_valid_i  = op_v & (sel == 2);
    assign ifd.op_valid_i  = op_v & (sel == 3);
    assign ifa.pkg_ready_i = rdy & (sel == 0);
    assign ifb.pkg_ready_i = rdy & (sel == 1);
    assign ifc.pkg_ready_i = rdy & (sel == 2);
    assign ifd.pkg_ready_i = rdy & (sel == 3);

    res_collector #(.NUM(4), .LATENCY(1), .CNT_W(16)) dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa.master));
    res_collector #(.NUM(4), .LATENCY(0), .CNT_W(16)) dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb.master));
    res_collector #(.NUM(4), .LATENCY(3), .CNT_W(16)) dut_c (.clk_i(clk), .reset_i(rst), .bus(ifc.master));
    res_collector #(.NUM(4), .LATENCY(1), .CNT_W(2))  dut_d (.clk_i(clk), .reset_i(rst), .bus(ifd.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe pattern pat (bit j = strobe on tick j); the next byte of vals
    // is presented lat ticks after each strobe, 0xFF otherwise.
    task automatic feed(input int lat, input int plen, input logic [15:0] pat, input logic [63:0] vals);
        int nb;
        nb = 0;
        for (int j = 0; j < plen + lat; j++) begin
            op_v  = (j < plen) ? pat[j] : 1'b0;
            res_v = 8'hFF;
            if (j >= lat && pat[j-lat]) begin
                res_v = vals[nb*8 +: 8];
                nb++;
            end
            tick();
        end
        op_v  = 1'b0;
        res_v = 8'hFF;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        sel   = 0;
        op_v  = 1'b0;
        rdy   = 1'b0;
        res_v = 8'hFF;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_data",  64'(ifa.pkg_data_o),  64'h0);
        check("rst_valid", 64'(ifa.pkg_valid_o), 64'h0);
        check("rst_cnt",   64'(ifa.byte_cnt_o),  64'h0);
        check("rst_drop",  64'(ifa.drop_cnt_o),  64'h0);
        check("rst_ovf",   64'(ifa.overflow_o),  64'h0);

        // Basic fill, LATENCY=1
        feed(1, 3, 16'b111, 64'h33_22_11);
        check("fill3_cnt",   64'(ifa.byte_cnt_o),  64'd3);
        check("fill3_valid", 64'(ifa.pkg_valid_o), 64'h0);
        check("fill3_data",  64'(ifa.pkg_data_o),  64'h0033_2211);
        feed(1, 1, 16'b1, 64'h44);
        check("fill_valid", 64'(ifa.pkg_valid_o), 64'h1);
        check("fill_data",  64'(ifa.pkg_data_o),  64'h4433_2211);
        check("fill_cnt",   64'(ifa.byte_cnt_o),  64'd4);

        // Backpressure drops
        feed(1, 3, 16'b111, 64'hEE_EE_EE);
        check("bp_data",  64'(ifa.pkg_data_o),  64'h4433_2211);
        check("bp_valid", 64'(ifa.pkg_valid_o), 64'h1);
        check("bp_drop",  64'(ifa.drop_cnt_o),  64'd3);
        check("bp_ovf",   64'(ifa.overflow_o),  64'h1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("hs_valid", 64'(ifa.pkg_valid_o), 64'h0);
        check("hs_cnt",   64'(ifa.byte_cnt_o),  64'd0);
        check("hs_data",  64'(ifa.pkg_data_o),  64'h0);
        check("hs_ovf",   64'(ifa.overflow_o),  64'h1);

        // Capture on the handshake cycle
        feed(1, 4, 16'b1111, 64'h04_03_02_01);
        check("p2_data", 64'(ifa.pkg_data_o), 64'h0403_0201);
        op_v = 1'b1;
        tick();
        op_v  = 1'b0;
        res_v = 8'hA5;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        res_v = 8'hFF;
        check("sim_valid", 64'(ifa.pkg_valid_o), 64'h0);
        check("sim_cnt",   64'(ifa.byte_cnt_o),  64'd1);
        check("sim_data",  64'(ifa.pkg_data_o),  64'hA5);
        check("sim_drop",  64'(ifa.drop_cnt_o),  64'd3);
        feed(1, 3, 16'b111, 64'hD8_C7_B6);
        check("p3_data",  64'(ifa.pkg_data_o),  64'hD8C7_B6A5);
        check("p3_valid", 64'(ifa.pkg_valid_o), 64'h1);

        // Latency sweep with gapped strobes
        sel = 1;
        feed(0, 7, 16'b1010101, 64'h8D_7C_6B_5A);
        check("l0_data",  64'(ifb.pkg_data_o),  64'h8D7C_6B5A);
        check("l0_valid", 64'(ifb.pkg_valid_o), 64'h1);
        sel = 2;
        feed(3, 7, 16'b1010101, 64'h8D_7C_6B_5A);
        check("l3_data",  64'(ifc.pkg_data_o),  64'h8D7C_6B5A);
        check("l3_valid", 64'(ifc.pkg_valid_o), 64'h1);
        check("l3_drop",  64'(ifc.drop_cnt_o),  64'd0);

        // Reset mid-package with a strobe in flight
        sel = 0;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        feed(1, 2, 16'b11, 64'h66_55);
        check("mid_cnt", 64'(ifa.byte_cnt_o), 64'd2);
        op_v = 1'b1;
        tick();
        op_v  = 1'b0;
        res_v = 8'h77;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_data",  64'(ifa.pkg_data_o),  64'h0);
        check("mr_valid", 64'(ifa.pkg_valid_o), 64'h0);
        check("mr_cnt",   64'(ifa.byte_cnt_o),  64'd0);
        check("mr_drop",  64'(ifa.drop_cnt_o),  64'd0);
        check("mr_ovf",   64'(ifa.overflow_o),  64'h0);
        res_v = 8'h99;
        tick();
        res_v = 8'hFF;
        check("mr_flush_cnt", 64'(ifa.byte_cnt_o), 64'd0);
        check("mr_flush_data", 64'(ifa.pkg_data_o), 64'h0);

        // Drop counter saturation, CNT_W=2
        sel = 3;
        feed(1, 4, 16'b1111, 64'h40_30_20_10);
        check("sat_fill", 64'(ifd.pkg_data_o), 64'h4030_2010);
        feed(1, 5, 16'b11111, 64'hEE_EE_EE_EE_EE);
        check("sat_drop",  64'(ifd.drop_cnt_o),  64'd3);
        check("sat_ovf",   64'(ifd.overflow_o),  64'h1);
        check("sat_data",  64'(ifd.pkg_data_o),  64'h4030_2010);
        check("sat_valid", 64'(ifd.pkg_valid_o), 64'h1);
        check("sat_cnt",   64'(ifd.byte_cnt_o),  64'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
